fadd_share_arb: RTL and testbench
=================================

Name: fadd_share_arb

Overview:
- Shares one combinational `fadd` (IEEE-754 single-precision adder; inputs a, b; output out) among N_REQ requesters.
- Round-robin arbitration, one operand pair accepted per cycle.
- Two-stage registered pipeline: operand stage S1, result stage S2.
- Each result returns tagged with the requester ID on a single valid/ready response channel.
- Sits between compute clients and the adder so that only one adder instance is needed.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a  in  32*N_REQ  operand A; slice i belongs to requester i.
- req_b  in  32*N_REQ  operand B; slice i belongs to requester i.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  32  sum, bit-exact with `fadd` out.
- busy  out  1  high when S1 or S2 holds a valid entry.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - s1_valid, rsp_valid, rr_ptr and busy all become 0.
  - rsp_data and rsp_id become 0.
  - In-flight operations are discarded with no response.
  - rst overrides any handshake in the same cycle.
- Stall logic:
  - s2_en = !rsp_valid | rsp_ready.
  - s1_en = !s1_valid | s2_en.
- Grant (combinational):
  - Choose the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around modulo N_REQ.
  - req_ready[g] = s1_en & req_valid[g]; all other bits are 0.
  - No request pending means no grant and rr_ptr holds.
- Handshake and rr_ptr:
  - A handshake occurs when req_valid[g] & req_ready[g] at a rising edge.
  - S1 captures a, b and id=g, and s1_valid becomes 1.
  - rr_ptr becomes (g+1) mod N_REQ.
  - rr_ptr updates only on a handshake.
- S1 to S2:
  - When s2_en, S2 captures fadd(s1_a, s1_b) into rsp_data and s1_id into rsp_id.
  - rsp_valid becomes s1_valid.
  - If s1_en and there is no new handshake, s1_valid becomes 0.
- Latency and throughput:
  - Handshake at edge t gives rsp_valid high after edge t+1 (2-cycle latency).
  - Full throughput of 1 result per cycle while rsp_ready stays high.
- Backpressure:
  - While rsp_valid & !rsp_ready, rsp_data and rsp_id hold stable.
  - S1 can still fill once if empty; after that req_ready is all zero.
  - Maximum occupancy is 2 entries.
- Simultaneous events:
  - A response handshake and a new request handshake in the same cycle both proceed; no bubble is inserted.
- Requester rules:
  - Requesters hold req_valid and operands stable until they see ready.
  - The grant may move to another requester while stalled, because no handshake occurred.
- Arithmetic:
  - No modification of `fadd` results; special values (Inf, NaN, ±0) pass through unchanged.
- busy = s1_valid | rsp_valid.

Decomposition:
- Package fadd_arb_pkg:
  - FP_W=32.
  - Constants FP_POS_INF=32'h7F800000 and FP_ZERO=32'h00000000 for benches.
  - Function for the request slice index.
- Sub-module rr_arbiter (req vector and ptr in; one-hot grant and binary index out) is natural and reusable.
- `fadd` is instanced once, ports connected positionally (a, b, out).

Test Plan:
- Single request:
  - Stimulus: req 1 only, a=3FC00000 (1.5), b=40200000 (2.5), rsp_ready=1.
  - Required: req_ready[1] is high in the same cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_data=40800000 (4.0); busy drops after the response.
- Special values, back-to-back on req 0:
  - Stimulus: first BF800000 + 3F800000, then 7F800000 + 40A00000.
  - Required: consecutive responses 00000000 then 7F800000, id 0 both, no bubble.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously with 40000000 + 40400000.
  - Required: grants 0,1,2,3,0 on consecutive cycles; rsp_id follows the same order 2 cycles later; every rsp_data=40A00000.
- Backpressure:
  - Stimulus: as in round-robin, but drop rsp_ready for 3 cycles.
  - Required: rsp_data and rsp_id frozen; req_ready all zero once S1 is full; after release, order resumes with no loss or duplication.
- Pointer hold:
  - Stimulus: after granting req 2, idle 5 cycles, then reqs 0 and 3 valid together.
  - Required: req 3 is granted first.
- Mid-operation reset:
  - Stimulus: assert rst for 1 cycle with both stages full.
  - Required: next cycle rsp_valid=0, busy=0, rsp_data=0; the following request from req 1 (with req 0 also valid) grants req 0 first, since rr_ptr=0.

Source files
------------

// File: rtl/fadd_arb_pkg.sv
// Shared constants and helpers for the shared-adder arbiter slice.
package fadd_arb_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;

    // LSB position of requester idx inside a packed operand bus
    function automatic int slice_lsb(input int idx);
        return idx * FP_W;
    endfunction

endpackage

// File: rtl/fadd.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// subnormals supported, NaN results canonicalised to 7FC00000.
module fadd (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out
);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (v[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + 5'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, swap_s, eff_sub_s, rnd_s;
    logic [31:0] x_s, y_s;
    logic [7:0]  ex_s, ey_s, d_s;
    logic [4:0]  d_cap_s, lz_s;
    logic [26:0] mx_s, my_s, my_al_s, norm_s;
    logic [53:0] sh_s;
    logic [27:0] sum_s;
    logic [9:0]  e_s, shl_s;
    logic [24:0] mr_s;
    logic [23:0] mant_s;

    // Align, add/subtract, normalise, round and pack
    always_comb begin
        a_nan_s = (&a[30:23]) && (|a[22:0]);
        b_nan_s = (&b[30:23]) && (|b[22:0]);
        a_inf_s = (&a[30:23]) && !(|a[22:0]);
        b_inf_s = (&b[30:23]) && !(|b[22:0]);
        swap_s  = b[30:0] > a[30:0];
        x_s     = swap_s ? b : a;
        y_s     = swap_s ? a : b;
        ex_s    = (x_s[30:23] == 8'd0) ? 8'd1 : x_s[30:23];
        ey_s    = (y_s[30:23] == 8'd0) ? 8'd1 : y_s[30:23];
        mx_s    = {(x_s[30:23] != 8'd0), x_s[22:0], 3'b000};
        my_s    = {(y_s[30:23] != 8'd0), y_s[22:0], 3'b000};
        d_s     = ex_s - ey_s;
        d_cap_s = (d_s > 8'd31) ? 5'd31 : d_s[4:0];
        sh_s    = {my_s, 27'd0} >> d_cap_s;
        // Bits shifted out collapse into the sticky position
        my_al_s   = {sh_s[53:28], sh_s[27] | (|sh_s[26:0])};
        eff_sub_s = x_s[31] ^ y_s[31];
        if (eff_sub_s) begin
            sum_s = {1'b0, mx_s} - {1'b0, my_al_s};
        end else begin
            sum_s = {1'b0, mx_s} + {1'b0, my_al_s};
        end
        lz_s = lzc27(sum_s[26:0]);
        if (sum_s[27]) begin
            norm_s = {sum_s[27:2], sum_s[1] | sum_s[0]};
            shl_s  = 10'd0;
            e_s    = {2'b00, ex_s} + 10'd1;
        end else begin
            // Left shift stops at exponent 1 so tiny results stay subnormal
            shl_s  = ({5'd0, lz_s} < ({2'b00, ex_s} - 10'd1)) ? {5'd0, lz_s} : ({2'b00, ex_s} - 10'd1);
            norm_s = sum_s[26:0] << shl_s;
            e_s    = {2'b00, ex_s} - shl_s;
        end
        rnd_s = norm_s[2] && (norm_s[3] || norm_s[1] || norm_s[0]);
        mr_s  = {1'b0, norm_s[26:3]} + {24'd0, rnd_s};
        if (mr_s[24]) begin
            mant_s = mr_s[24:1];
            e_s    = e_s + 10'd1;
        end else begin
            mant_s = mr_s[23:0];
            e_s    = e_s;
        end
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a[31] != b[31]))) begin
            out = 32'h7FC0_0000;
        end else if (a_inf_s) begin
            out = a;
        end else if (b_inf_s) begin
            out = b;
        end else if (sum_s == 28'd0) begin
            out = {x_s[31] & y_s[31], 31'd0};
        end else if (e_s >= 10'd255) begin
            out = {x_s[31], 8'hFF, 23'd0};
        end else begin
            out = {x_s[31], (mant_s[23] ? e_s[7:0] : 8'd0), mant_s[22:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          hit
);

    // Rotating priority search starting at ptr
    always_comb begin
        gnt = {N{1'b0}};
        idx = {IW{1'b0}};
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!hit && req[(int'(ptr) + k) % N]) begin
                hit                      = 1'b1;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx                      = IW'((int'(ptr) + k) % N);
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/fadd_share_arb.sv
// Shares one combinational fadd among N_REQ requesters through a
// round-robin grant and a two-stage (operand, result) pipeline.
module fadd_share_arb
    import fadd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [FP_W*N_REQ-1:0]   req_a,
    input  logic [FP_W*N_REQ-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_data,
    output logic                    busy
);

    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gnt_idx_s, rr_ptr_r, rr_ptr_nxt_s, s1_id_r, rsp_id_r;
    logic             gnt_hit_s, s1_en_s, s2_en_s, hs_s;
    logic             s1_valid_r, s1_valid_nxt_s, rsp_valid_r, rsp_valid_nxt_s, busy_r;
    logic [FP_W-1:0]  s1_a_r, s1_b_r, sum_s, rsp_data_r;

    rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .gnt (gnt_s),
        .idx (gnt_idx_s),
        .hit (gnt_hit_s)
    );

    fadd u_fadd (s1_a_r, s1_b_r, sum_s);

    // Stall chain, grant qualification and next-state terms
    always_comb begin
        s2_en_s   = !rsp_valid_r || rsp_ready;
        s1_en_s   = !s1_valid_r || s2_en_s;
        hs_s      = gnt_hit_s && s1_en_s;
        req_ready = s1_en_s ? gnt_s : {N_REQ{1'b0}};
        if (hs_s) begin
            s1_valid_nxt_s = 1'b1;
        end else if (s1_en_s) begin
            s1_valid_nxt_s = 1'b0;
        end else begin
            s1_valid_nxt_s = s1_valid_r;
        end
        rsp_valid_nxt_s = s2_en_s ? s1_valid_r : rsp_valid_r;
        if (int'(gnt_idx_s) == N_REQ - 1) begin
            rr_ptr_nxt_s = {ID_W{1'b0}};
        end else begin
            rr_ptr_nxt_s = ID_W'(int'(gnt_idx_s) + 1);
        end
    end

    // Pipeline registers; busy is registered from the next-state valids
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {FP_W{1'b0}};
            s1_b_r      <= {FP_W{1'b0}};
            s1_id_r     <= {ID_W{1'b0}};
            rr_ptr_r    <= {ID_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {FP_W{1'b0}};
            rsp_id_r    <= {ID_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            busy_r      <= s1_valid_nxt_s | rsp_valid_nxt_s;
            if (hs_s) begin
                s1_a_r   <= req_a[slice_lsb(int'(gnt_idx_s)) +: FP_W];
                s1_b_r   <= req_b[slice_lsb(int'(gnt_idx_s)) +: FP_W];
                s1_id_r  <= gnt_idx_s;
                rr_ptr_r <= rr_ptr_nxt_s;
            end
            // Result stage freezes while the consumer stalls
            if (s2_en_s) begin
                rsp_data_r <= sum_s;
                rsp_id_r   <= s1_id_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fadd_share_arb.sv
// Directed bench for fadd_share_arb with a scoreboard queue of expected responses.
module tb_fadd_share_arb;
    import fadd_arb_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready;
    logic [32*N-1:0]   req_a, req_b;
    logic              rsp_valid, rsp_ready, busy;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_data;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_sum [N];
    int          q_id [$];
    logic [31:0] q_data [$];

    always #5 clk = ~clk;

    fadd_share_arb #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        exp_sum[i]        = s;
        req_valid[i]      = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            step();
        end
        sample();
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    // Monitor: pops on each response handshake, pushes on each request handshake
    always @(negedge clk) begin
        if (rst) begin
            q_id.delete();
            q_data.delete();
        end else begin
            chk("ready_onehot", 32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == 4'd0)), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (q_id.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got id %0d data %h, required no response", rsp_id, rsp_data);
                end else begin
                    chk("rsp_id", 32'(rsp_id), 32'(q_id.pop_front()));
                    chk("rsp_data", rsp_data, q_data.pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q_id.push_back(i);
                    q_data.push_back(exp_sum[i]);
                end
            end
        end
    end

    initial begin
        logic [31:0] sel;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'd0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) exp_sum[i] = 32'd0;
        repeat (2) step();
        sample();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", rsp_data, FP_ZERO);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);

        // Single request on requester 1
        step();
        rst = 1'b0;
        set_req(1, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
        sample(); chk("t1_ready", 32'(req_ready), 32'h2);
        step(); req_valid = 4'd0;
        sample(); chk("t1_lat_lo", 32'(rsp_valid), 32'd0); chk("t1_busy", 32'(busy), 32'd1);
        step(); sample(); chk("t1_valid", 32'(rsp_valid), 32'd1);
        step(); sample(); chk("t1_idle", 32'(busy), 32'd0);

        // Special values back-to-back on requester 0
        step(); set_req(0, 32'hBF80_0000, 32'h3F80_0000, FP_ZERO);
        sample(); chk("t2_ready_a", 32'(req_ready), 32'h1);
        step(); set_req(0, FP_POS_INF, 32'h40A0_0000, FP_POS_INF);
        sample(); chk("t2_ready_b", 32'(req_ready), 32'h1);
        step(); req_valid = 4'd0;
        sample(); chk("t2_first", 32'(rsp_valid), 32'd1);
        step(); sample(); chk("t2_nobubble", 32'(rsp_valid), 32'd1);
        step(); sample(); chk("t2_done", 32'(rsp_valid), 32'd0);

        // Requester 3 alone moves the pointer back to 0
        step(); set_req(3, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        sample(); chk("t3_pre_ready", 32'(req_ready), 32'h8);
        step(); req_valid = 4'd0;
        drain();

        // Round-robin with all requesters valid
        step();
        for (int i = 0; i < N; i++) set_req(i, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);
        for (int k = 0; k < 5; k++) begin
            sel = 32'd1 << (k % 4);
            sample(); chk("rr_grant", 32'(req_ready), sel);
            step();
        end
        req_valid = 4'd0;
        drain();

        // Backpressure: pointer sits at 1
        step();
        for (int i = 0; i < N; i++) set_req(i, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);
        sample(); chk("bp_g1", 32'(req_ready), 32'h2);
        step(); sample(); chk("bp_g2", 32'(req_ready), 32'h4);
        step(); sample(); chk("bp_g3", 32'(req_ready), 32'h8);
        step(); rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("bp_stall_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_id", 32'(rsp_id), 32'd2);
            chk("bp_hold_data", rsp_data, 32'h40A0_0000);
            step();
        end
        rsp_ready = 1'b1;
        sample(); chk("bp_resume_g0", 32'(req_ready), 32'h1);
        step(); sample(); chk("bp_resume_g1", 32'(req_ready), 32'h2);
        step(); req_valid = 4'd0;
        drain();

        // Pointer hold across idle cycles
        step(); set_req(2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000);
        sample(); chk("ph_g2", 32'(req_ready), 32'h4);
        step(); req_valid = 4'd0;
        repeat (5) step();
        set_req(0, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);
        set_req(3, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        sample(); chk("ph_first_g3", 32'(req_ready), 32'h8);
        step(); sample(); chk("ph_then_g0", 32'(req_ready), 32'h1);
        step(); req_valid = 4'd0;
        drain();

        // Reset with both stages occupied
        step(); rsp_ready = 1'b0;
        set_req(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        sample(); chk("mr_g1", 32'(req_ready), 32'h2);
        step(); sample(); chk("mr_fill_s1", 32'(req_ready), 32'h2);
        step(); sample();
        chk("mr_full_ready", 32'(req_ready), 32'd0);
        chk("mr_full_busy", 32'(busy), 32'd1);
        chk("mr_full_valid", 32'(rsp_valid), 32'd1);
        step(); rst = 1'b1; req_valid = 4'd0;
        sample();
        step(); rst = 1'b0; rsp_ready = 1'b1;
        sample();
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rsp_data", rsp_data, FP_ZERO);
        chk("mr_rsp_id", 32'(rsp_id), 32'd0);
        step();
        set_req(0, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);
        set_req(1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        sample(); chk("mr_ptr0_g0", 32'(req_ready), 32'h1);
        step(); sample(); chk("mr_then_g1", 32'(req_ready), 32'h2);
        step(); req_valid = 4'd0;
        drain();

        chk("sb_empty", 32'(q_id.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
